operand_hazard_ctrl: RTL and testbench
======================================

Name: operand_hazard_ctrl

Overview:
Issue controller in front of operand_fetch. It keeps a scoreboard of registers with pending writebacks and holds back any decoded instruction whose source or destination registers are still pending. It drives the register-file read enables and a valid/ready handshake between decode, operand fetch and execute. It also counts hazard stall cycles for performance monitoring.

Parameters:
NUM_REGS, 32, number of architectural registers tracked; all 32 are tracked, with no hardwired-zero register.
IDX_W, 5, register index width; must equal log2(NUM_REGS).
CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
id_valid  input  1  decode holds a valid instruction
id_ready  output  1  controller accepts the instruction this cycle
id_addr_mode  input  1  0 = direct (operand B read from a register), 1 = immediate
id_reg_idx_a  input  IDX_W  source A index, also the destination index
id_reg_idx_b  input  IDX_W  source B index
id_has_writeback  input  1  instruction writes id_reg_idx_a
reg_r_en_a  output  1  register-file read enable, port A
reg_r_en_b  output  1  register-file read enable, port B
of_valid  output  1  registered; an operand-fetch result is valid toward execute
ex_ready  input  1  execute accepts the result
of_reg_idx_dst  output  IDX_W  registered destination index of the issued instruction
of_has_writeback  output  1  registered writeback flag of the issued instruction
wb_en  input  1  writeback commit this cycle
wb_idx  input  IDX_W  register being committed
busy_vec  output  NUM_REGS  scoreboard contents
hazard_stall  output  1  combinational; the current cycle is stalled by a hazard
stall_cnt  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, active-low): busy_vec, of_valid, of_reg_idx_dst, of_has_writeback and stall_cnt all go to 0; FSM goes to RUN. Reset mid-operation discards all in-flight state.
- clr_mask = onehot(wb_idx) when wb_en is high, else 0. busy_eff = busy_vec & ~clr_mask, so a writeback clears its register in the same cycle it is checked.
- raw_a = busy_eff[id_reg_idx_a].
- raw_b = (id_addr_mode == 0) & busy_eff[id_reg_idx_b].
- waw = id_has_writeback & busy_eff[id_reg_idx_a].
- hazard = raw_a | raw_b | waw.
- hazard_stall = id_valid & hazard.
- slot_free = ~of_valid | ex_ready.
- id_ready = ~hazard & slot_free.
- issue = id_valid & id_ready.
- Read enables: reg_r_en_a = issue. reg_r_en_b = issue & (id_addr_mode == 0). Both are low in every other case.
- Output register, on a clock edge:
  - if issue: of_valid <= 1; of_reg_idx_dst <= id_reg_idx_a; of_has_writeback <= id_has_writeback.
  - else if ex_ready: of_valid <= 0.
  - otherwise hold all three.
- Result latency: one cycle from issue to of_valid.
- Scoreboard update: busy_next = (busy_vec & ~clr_mask) | set_mask, where set_mask = onehot(id_reg_idx_a) when issue & id_has_writeback.
- Set wins over clear when both target the same index in the same cycle.
- A wb_en for a register that is not busy is harmless; the bit stays 0.
- FSM states, evaluated each cycle:
  - RUN: the default state; the last cycle issued or was idle.
  - STALL: id_valid & hazard.
  - HOLD: id_valid & ~hazard & ~slot_free, i.e. backpressure from execute.
  - Any state moves to STALL, HOLD or RUN according to the conditions above. Hazard takes priority, so when both apply the state is STALL.
- stall_cnt increments by 1 on every cycle the state is STALL. It saturates at all-ones and never wraps.
- Back-to-back independent instructions issue every cycle while ex_ready is held high.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_MODE_DIRECT = 1'b0 and ADDR_MODE_IMMEDIATE = 1'b1
  - the register index width
  - the FSM state encoding (RUN, STALL, HOLD)
- One natural sub-module, reg_scoreboard: the busy vector with set/clear ports and the combinational busy_eff lookup for three indices. The handshake, FSM and counter stay in the top level.

Test Plan:
- Reset with busy_vec preloaded through issues, assert reset=0 mid-run -> busy_vec=0, of_valid=0, stall_cnt=0 immediately, without waiting for a clock.
- RAW: issue r3 with writeback, then next cycle an instruction reading a=r3 -> id_ready=0 and hazard_stall=1. Assert wb_en with wb_idx=3 three cycles later -> id_ready=1 in that same cycle, stall_cnt=3.
- Immediate mode: r5 busy, id_addr_mode=1, id_reg_idx_b=5, a=r1 -> issue proceeds; reg_r_en_b=0, reg_r_en_a=1.
- WAW plus set/clear collision: r7 busy, new instruction writes r7 while wb_en with wb_idx=7 in the same cycle -> issues, and busy_vec[7] stays 1.
- Backpressure: ex_ready=0 with of_valid=1, independent instruction arrives -> id_ready=0, hazard_stall=0, state HOLD, stall_cnt unchanged, outputs held. Then ex_ready=1 -> issues that cycle.
- Saturation: force 65540 hazard cycles -> stall_cnt=16'hFFFF and holds there.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the issue/operand-fetch slice: addressing modes,
// register index width and the hazard controller's state encoding.
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_ARCH_REGS = 1 << REG_IDX_W;

    localparam logic ADDR_MODE_DIRECT    = 1'b0;
    localparam logic ADDR_MODE_IMMEDIATE = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register, with a commit
// clear that is visible to lookups in the same cycle it arrives.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int IDX_W    = REG_IDX_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic                clr_en,
    input  logic [IDX_W-1:0]    clr_idx,
    input  logic [IDX_W-1:0]    look_idx_0,
    input  logic [IDX_W-1:0]    look_idx_1,
    input  logic [IDX_W-1:0]    look_idx_2,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                busy_0,
    output logic                busy_1,
    output logic                busy_2
);

    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] busy_eff;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        if (set_en) set_mask[set_idx] = 1'b1;
    end

    assign busy_eff = busy_vec & ~clr_mask;

    assign busy_0 = busy_eff[look_idx_0];
    assign busy_1 = busy_eff[look_idx_1];
    assign busy_2 = busy_eff[look_idx_2];

    // OR-ing the set mask after the clear lets a new writer keep the bit
    // when the previous writer to the same register commits this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_vec <= '0;
        else        busy_vec <= busy_eff | set_mask;
    end

endmodule

// File: rtl/operand_hazard_ctrl.sv
// Issue controller in front of operand fetch: blocks RAW/WAW hazards against
// the scoreboard, drives register-file read enables and counts stall cycles.
module operand_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int IDX_W    = REG_IDX_W,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic                id_addr_mode,
    input  logic [IDX_W-1:0]    id_reg_idx_a,
    input  logic [IDX_W-1:0]    id_reg_idx_b,
    input  logic                id_has_writeback,
    output logic                reg_r_en_a,
    output logic                reg_r_en_b,
    output logic                of_valid,
    input  logic                ex_ready,
    output logic [IDX_W-1:0]    of_reg_idx_dst,
    output logic                of_has_writeback,
    input  logic                wb_en,
    input  logic [IDX_W-1:0]    wb_idx,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                hazard_stall,
    output logic [CNT_W-1:0]    stall_cnt,
    output hazard_state_t       fsm_state
);

    // Handshake: a transfer happens on a clock edge where valid and ready are
    // both high; valid never depends on ready, and ready here depends only on
    // scoreboard state and whether the output slot drains this cycle.

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic busy_a;
    logic busy_b;
    logic busy_dst;
    logic raw_a;
    logic raw_b;
    logic waw;
    logic hazard;
    logic slot_free;
    logic issue;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (issue & id_has_writeback),
        .set_idx    (id_reg_idx_a),
        .clr_en     (wb_en),
        .clr_idx    (wb_idx),
        .look_idx_0 (id_reg_idx_a),
        .look_idx_1 (id_reg_idx_b),
        .look_idx_2 (id_reg_idx_a),
        .busy_vec   (busy_vec),
        .busy_0     (busy_a),
        .busy_1     (busy_b),
        .busy_2     (busy_dst)
    );

    assign raw_a     = busy_a;
    assign raw_b     = (id_addr_mode == ADDR_MODE_DIRECT) & busy_b;
    assign waw       = id_has_writeback & busy_dst;
    assign hazard    = raw_a | raw_b | waw;

    assign hazard_stall = id_valid & hazard;
    assign slot_free    = ~of_valid | ex_ready;
    assign id_ready     = ~hazard & slot_free;
    assign issue        = id_valid & id_ready;

    assign reg_r_en_a = issue;
    assign reg_r_en_b = issue & (id_addr_mode == ADDR_MODE_DIRECT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            of_valid         <= 1'b0;
            of_reg_idx_dst   <= '0;
            of_has_writeback <= 1'b0;
        end else if (issue) begin
            of_valid         <= 1'b1;
            of_reg_idx_dst   <= id_reg_idx_a;
            of_has_writeback <= id_has_writeback;
        end else if (ex_ready) begin
            of_valid         <= 1'b0;
        end
    end

    // fsm_state records how the previous cycle was classified; the counter
    // advances on the same condition so it already includes the cycle that
    // the state now reports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_state <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            if (id_valid && hazard) begin
                fsm_state <= ST_STALL;
                if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_ONE;
            end else if (id_valid && !slot_free) begin
                fsm_state <= ST_HOLD;
            end else begin
                fsm_state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Directed bench for operand_hazard_ctrl: a set-of-pending-registers model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_operand_hazard_ctrl;
    import cpu_pkg::*;

    logic            clk;
    logic            reset;
    logic            id_valid;
    logic            id_ready;
    logic            id_addr_mode;
    logic [4:0]      id_reg_idx_a;
    logic [4:0]      id_reg_idx_b;
    logic            id_has_writeback;
    logic            reg_r_en_a;
    logic            reg_r_en_b;
    logic            of_valid;
    logic            ex_ready;
    logic [4:0]      of_reg_idx_dst;
    logic            of_has_writeback;
    logic            wb_en;
    logic [4:0]      wb_idx;
    logic [31:0]     busy_vec;
    logic            hazard_stall;
    logic [15:0]     stall_cnt;
    hazard_state_t   fsm_state;

    int checks = 0;
    int errors = 0;

    operand_hazard_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_addr_mode     (id_addr_mode),
        .id_reg_idx_a     (id_reg_idx_a),
        .id_reg_idx_b     (id_reg_idx_b),
        .id_has_writeback (id_has_writeback),
        .reg_r_en_a       (reg_r_en_a),
        .reg_r_en_b       (reg_r_en_b),
        .of_valid         (of_valid),
        .ex_ready         (ex_ready),
        .of_reg_idx_dst   (of_reg_idx_dst),
        .of_has_writeback (of_has_writeback),
        .wb_en            (wb_en),
        .wb_idx           (wb_idx),
        .busy_vec         (busy_vec),
        .hazard_stall     (hazard_stall),
        .stall_cnt        (stall_cnt),
        .fsm_state        (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending registers are a plain set of flags; everything else is derived
    // directly from the issue rules.
    bit  pend[32];
    bit  ov_m;
    int  dst_m;
    bit  hwb_m;
    int  cnt_m;
    int  st_m;

    function automatic bit pending_now(int r);
        return pend[r] && !(wb_en && int'(wb_idx) == r);
    endfunction

    function automatic bit m_hazard();
        bit a_busy;
        a_busy = pending_now(int'(id_reg_idx_a));
        return a_busy || (id_addr_mode == 1'b0 && pending_now(int'(id_reg_idx_b)))
               || (id_has_writeback && a_busy);
    endfunction

    function automatic bit m_ready();
        return !m_hazard() && (!ov_m || ex_ready);
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) pend[i] = 1'b0;
            ov_m = 0; dst_m = 0; hwb_m = 0; cnt_m = 0; st_m = int'(ST_RUN);
        end else begin
            bit hz, rdy, iss;
            hz  = m_hazard();
            rdy = m_ready();
            iss = id_valid && rdy;
            if (id_valid && hz) begin
                st_m = int'(ST_STALL);
                if (cnt_m < 65535) cnt_m++;
            end else if (id_valid && ov_m && !ex_ready) st_m = int'(ST_HOLD);
            else st_m = int'(ST_RUN);
            if (wb_en) pend[wb_idx] = 1'b0;
            if (iss && id_has_writeback) pend[id_reg_idx_a] = 1'b1;
            if (iss) begin
                ov_m = 1; dst_m = int'(id_reg_idx_a); hwb_m = id_has_writeback;
            end else if (ex_ready) ov_m = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            bit rdy;
            rdy = m_ready();
            chk("id_ready",         32'(id_ready),         32'(rdy));
            chk("reg_r_en_a",       32'(reg_r_en_a),       32'(id_valid && rdy));
            chk("reg_r_en_b",       32'(reg_r_en_b),       32'(id_valid && rdy && !id_addr_mode));
            chk("hazard_stall",     32'(hazard_stall),     32'(id_valid && m_hazard()));
            chk("of_valid",         32'(of_valid),         32'(ov_m));
            chk("of_reg_idx_dst",   32'(of_reg_idx_dst),   32'(dst_m));
            chk("of_has_writeback", 32'(of_has_writeback), 32'(hwb_m));
            chk("busy_vec",         busy_vec,              m_busy_vec());
            chk("stall_cnt",        32'(stall_cnt),        32'(cnt_m));
            chk("fsm_state",        32'(fsm_state),        32'(st_m));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic mode, input logic hwb);
        id_valid = v; id_reg_idx_a = a; id_reg_idx_b = b;
        id_addr_mode = mode; id_has_writeback = hwb;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] r);
        wb_en = 1'b1; wb_idx = r;
        step();
        wb_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, ADDR_MODE_DIRECT, 1'b0);
        ex_ready = 1'b1; wb_en = 1'b0; wb_idx = 5'd0;
        #2;
        chk("reset_busy_vec", busy_vec, 32'h0);
        chk("reset_of_valid", 32'(of_valid), 32'h0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
        #10 reset = 1'b1;
        step();

        // RAW on r3, cleared by a commit three cycles after the stall begins
        drive(1'b1, 5'd3, 5'd0, ADDR_MODE_DIRECT, 1'b1);
        settle();
        chk("raw_first_issue", 32'(reg_r_en_a), 32'h1);
        step();
        drive(1'b1, 5'd3, 5'd4, ADDR_MODE_DIRECT, 1'b0);
        settle();
        chk("raw_ready", 32'(id_ready), 32'h0);
        chk("raw_stall", 32'(hazard_stall), 32'h1);
        step(3);
        wb_en = 1'b1; wb_idx = 5'd3;
        settle();
        chk("raw_wb_ready", 32'(id_ready), 32'h1);
        chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("raw_state", 32'(fsm_state), 32'(ST_STALL));
        step();
        wb_en = 1'b0;

        // Immediate mode ignores a busy operand B
        drive(1'b1, 5'd5, 5'd0, ADDR_MODE_DIRECT, 1'b1);
        step();
        drive(1'b1, 5'd1, 5'd5, ADDR_MODE_IMMEDIATE, 1'b1);
        settle();
        chk("imm_ready", 32'(id_ready), 32'h1);
        chk("imm_r_en_a", 32'(reg_r_en_a), 32'h1);
        chk("imm_r_en_b", 32'(reg_r_en_b), 32'h0);
        step();
        drive(1'b0, 5'd0, 5'd0, ADDR_MODE_DIRECT, 1'b0);
        commit(5'd5);
        commit(5'd1);

        // WAW stall, then a writer and a commit to r7 in the same cycle
        drive(1'b1, 5'd7, 5'd0, ADDR_MODE_DIRECT, 1'b1);
        step();
        drive(1'b1, 5'd7, 5'd0, ADDR_MODE_IMMEDIATE, 1'b1);
        settle();
        chk("waw_ready", 32'(id_ready), 32'h0);
        chk("waw_stall", 32'(hazard_stall), 32'h1);
        step();
        wb_en = 1'b1; wb_idx = 5'd7;
        settle();
        chk("collide_ready", 32'(id_ready), 32'h1);
        step();
        wb_en = 1'b0;

        // Backpressure: independent instruction behind a stalled result
        drive(1'b1, 5'd10, 5'd11, ADDR_MODE_IMMEDIATE, 1'b0);
        ex_ready = 1'b0;
        settle();
        chk("collide_busy7", 32'(busy_vec[7]), 32'h1);
        chk("bp_ready", 32'(id_ready), 32'h0);
        chk("bp_stall", 32'(hazard_stall), 32'h0);
        step();
        settle();
        chk("bp_state", 32'(fsm_state), 32'(ST_HOLD));
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("bp_hold_dst", 32'(of_reg_idx_dst), 32'd7);
        chk("bp_hold_valid", 32'(of_valid), 32'h1);
        ex_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(id_ready), 32'h1);
        step();
        settle();
        chk("bp_new_dst", 32'(of_reg_idx_dst), 32'd10);
        chk("bp_new_hwb", 32'(of_has_writeback), 32'h0);
        drive(1'b0, 5'd0, 5'd0, ADDR_MODE_DIRECT, 1'b0);
        step();
        commit(5'd7);

        // Back-to-back independent writers, then an asynchronous reset mid-run
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(16 + i), 5'(i), ADDR_MODE_DIRECT, 1'b1);
            step();
        end
        drive(1'b0, 5'd0, 5'd0, ADDR_MODE_DIRECT, 1'b0);
        settle();
        chk("b2b_busy", busy_vec, 32'h00FF_0000);
        #1 reset = 1'b0;
        #1;
        chk("midreset_busy_vec", busy_vec, 32'h0);
        chk("midreset_of_valid", 32'(of_valid), 32'h0);
        chk("midreset_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("midreset_state", 32'(fsm_state), 32'(ST_RUN));
        step();
        #2 reset = 1'b1;
        step();

        // Saturation: a single instruction stuck on r9 for 65540 cycles
        drive(1'b1, 5'd9, 5'd0, ADDR_MODE_DIRECT, 1'b1);
        step();
        drive(1'b1, 5'd9, 5'd0, ADDR_MODE_IMMEDIATE, 1'b0);
        step(65540);
        settle();
        chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
        step(3);
        settle();
        chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
        drive(1'b0, 5'd0, 5'd0, ADDR_MODE_DIRECT, 1'b0);
        commit(5'd9);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
